// File: rtl/uart_proto_pkg.sv
//------------------------------------------------------------------------------
// Module : uart_proto_pkg
// Brief  : Packet field positions, byte counts and FSM states shared by the
//          UART memory client.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_proto_pkg;

    localparam int CMD_WRITE_BIT    = 7;
    localparam int CMD_MASK_LSB     = 0;
    localparam int READ_REPLY_BYTES = 4;
    localparam int WRITE_DATA_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_CMD  = 3'd1,
        ST_SEND_ADDR = 3'd2,
        ST_SEND_DATA = 3'd3,
        ST_WAIT_RESP = 3'd4,
        ST_RESP      = 3'd5
    } client_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_mem_client.sv
//------------------------------------------------------------------------------
// Module : uart_mem_client
// Brief  : Turns one CPU memory request into a UART request packet and, for
//          reads, assembles the 4-byte reply under a response timeout.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_mem_client #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_mask,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              send_flag,
    output logic [7:0]        send_data,
    input  logic              send_able,
    output logic              recv_flag,
    input  logic [7:0]        recv_data,
    input  logic              recv_able
);
    import uart_proto_pkg::*;

    localparam int ADDR_BYTES = ADDR_W / 8;
    localparam int IDX_W      = (ADDR_BYTES > 4) ? $clog2(ADDR_BYTES) : 2;
    localparam int TMO_W      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] c_addr_last  = IDX_W'(ADDR_BYTES - 1);
    localparam logic [1:0]       c_data_last  = 2'(WRITE_DATA_BYTES - 1);
    localparam logic [1:0]       c_reply_last = 2'(READ_REPLY_BYTES - 1);
    localparam logic [TMO_W-1:0] c_tmo_last   = TMO_W'(TIMEOUT_CYCLES - 1);

    client_state_t     r_state, w_state_nxt;
    logic              r_write, w_write_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [31:0]       r_wdata, w_wdata_nxt;
    logic [3:0]        r_mask, w_mask_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;

    logic              r_req_ready, w_req_ready_nxt;
    logic              r_resp_valid, w_resp_valid_nxt;
    logic [31:0]       r_rdata, w_rdata_nxt;
    logic              r_err, w_err_nxt;
    logic              r_send_flag, w_send_flag_nxt;
    logic [7:0]        r_send_data, w_send_data_nxt;
    logic              r_recv_flag, w_recv_flag_nxt;

    logic              w_push_ok;
    logic              w_pop_ok;
    logic [7:0]        w_cmd;

    // A strobe registered last cycle means the FIFO flag has not caught up yet.
    assign w_push_ok = send_able && !r_send_flag;
    assign w_pop_ok  = recv_able && !r_recv_flag;

    always_comb begin
        w_cmd                    = '0;
        w_cmd[CMD_WRITE_BIT]     = r_write;
        w_cmd[CMD_MASK_LSB +: 4] = r_mask;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_write_nxt     = r_write;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_mask_nxt      = r_mask;
        w_idx_nxt       = r_idx;
        w_tmo_nxt       = r_tmo;
        w_rdata_nxt     = r_rdata;
        w_err_nxt       = r_err;
        w_send_flag_nxt = 1'b0;
        w_send_data_nxt = r_send_data;
        w_recv_flag_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_pop_ok) begin
                    w_recv_flag_nxt = 1'b1;
                end
                if (req_valid) begin
                    w_write_nxt = req_write;
                    w_addr_nxt  = req_addr;
                    w_wdata_nxt = req_wdata;
                    w_mask_nxt  = req_write ? req_mask : 4'h0;
                    w_rdata_nxt = '0;
                    w_err_nxt   = 1'b0;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_SEND_CMD;
                end
            end

            ST_SEND_CMD: begin
                if (w_push_ok) begin
                    w_send_flag_nxt = 1'b1;
                    w_send_data_nxt = w_cmd;
                    w_idx_nxt       = '0;
                    w_state_nxt     = ST_SEND_ADDR;
                end
            end

            ST_SEND_ADDR: begin
                if (w_push_ok) begin
                    w_send_flag_nxt = 1'b1;
                    w_send_data_nxt = r_addr[{r_idx, 3'b000} +: 8];
                    if (r_idx == c_addr_last) begin
                        w_idx_nxt = '0;
                        if (r_write) begin
                            w_state_nxt = ST_SEND_DATA;
                        end else begin
                            w_tmo_nxt   = '0;
                            w_state_nxt = ST_WAIT_RESP;
                        end
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end

            ST_SEND_DATA: begin
                if (w_push_ok) begin
                    w_send_flag_nxt = 1'b1;
                    w_send_data_nxt = r_wdata[{r_idx[1:0], 3'b000} +: 8];
                    if (r_idx[1:0] == c_data_last) begin
                        w_idx_nxt   = '0;
                        w_err_nxt   = 1'b0;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end

            ST_WAIT_RESP: begin
                // A captured byte takes priority over an expiring timeout.
                if (w_pop_ok) begin
                    w_recv_flag_nxt = 1'b1;
                    w_rdata_nxt[{r_idx[1:0], 3'b000} +: 8] = recv_data;
                    w_tmo_nxt = '0;
                    if (r_idx[1:0] == c_reply_last) begin
                        w_idx_nxt   = '0;
                        w_err_nxt   = 1'b0;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else if (r_tmo == c_tmo_last) begin
                    w_rdata_nxt = '0;
                    w_err_nxt   = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end

            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_resp_valid_nxt = (w_state_nxt == ST_RESP);
        w_req_ready_nxt  = (w_state_nxt == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mask       <= '0;
            r_idx        <= '0;
            r_tmo        <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_send_flag  <= 1'b0;
            r_send_data  <= '0;
            r_recv_flag  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_write      <= w_write_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_mask       <= w_mask_nxt;
            r_idx        <= w_idx_nxt;
            r_tmo        <= w_tmo_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_rdata      <= w_rdata_nxt;
            r_err        <= w_err_nxt;
            r_send_flag  <= w_send_flag_nxt;
            r_send_data  <= w_send_data_nxt;
            r_recv_flag  <= w_recv_flag_nxt;
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign send_flag  = r_send_flag;
    assign send_data  = r_send_data;
    assign recv_flag  = r_recv_flag;

endmodule

`default_nettype wire
